// File: rtl/v2f_divmod_seq.sv
// ---------------------------------------------------------------------------
// v2f_divmod_seq
//   Multi-cycle integer divide/modulo unit. It produces the quotient and the
//   remainder of one request together. Division truncates toward zero, and
//   x/0 returns quot = rem = 0 with div_by_zero set.
//   A restoring shift-subtract datapath resolves one quotient bit per cycle,
//   MSB first, on the operand magnitudes. Signs are applied at the end.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_valid     request valid
//   in_ready     unit can accept a request (high only in IDLE)
//   a, b         dividend, divisor (sampled on the accept edge only)
//   out_valid    result valid (high only in DONE)
//   out_ready    consumer accepts the result
//   quot, rem    quotient, remainder (held until the next result loads)
//   div_by_zero  result came from b == 0
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for a request, in_ready = 1
// CALC   | WIDTH shift-subtract iterations in progress
// DONE   | result presented on out_valid until out_ready
// ---------------------------------------------------------------------------
module v2f_divmod_seq #(
    parameter int WIDTH  = 32,
    parameter int SIGNED = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             div_by_zero
);

    localparam int CW  = $clog2(WIDTH + 1);
    localparam bit SGN = (SIGNED != 0);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] dvs;       // divisor magnitude
    logic [WIDTH-1:0] dvd;       // dividend bits shift out, quotient bits shift in
    logic [WIDTH:0]   prem;      // partial remainder
    logic             neg_q;
    logic             neg_r;

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH+1:0] sub;
    logic             borrow;
    logic [WIDTH:0]   prem_nxt;
    logic [WIDTH-1:0] dvd_nxt;
    logic [WIDTH-1:0] q_fin;
    logic [WIDTH-1:0] r_fin;

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);

    always_comb begin
        a_neg = SGN & a[WIDTH-1];
        b_neg = SGN & b[WIDTH-1];
        // The WIDTH-bit two's-complement negation, read as unsigned, equals the
        // true WIDTH+1-bit magnitude. This holds for MIN too (-MIN -> 2^(WIDTH-1)).
        a_mag = a_neg ? (-a) : a;
        b_mag = b_neg ? (-b) : b;

        // prem < dvs always, so the shifted value fits WIDTH+1 bits. The extra
        // MSB in the subtraction gives the borrow.
        rem_shift = (prem << 1) | {{WIDTH{1'b0}}, dvd[WIDTH-1]};
        sub       = {1'b0, rem_shift} - {2'b00, dvs};
        borrow    = sub[WIDTH+1];
        prem_nxt  = borrow ? rem_shift : sub[WIDTH:0];
        dvd_nxt   = {dvd[WIDTH-2:0], ~borrow};

        // MIN / -1 wraps naturally: magnitude 2^(WIDTH-1) is stored unnegated.
        q_fin = neg_q ? (-dvd_nxt) : dvd_nxt;
        r_fin = neg_r ? (-prem_nxt[WIDTH-1:0]) : prem_nxt[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            dvs         <= '0;
            dvd         <= '0;
            prem        <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            quot        <= '0;
            rem         <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        dvd   <= a_mag;
                        dvs   <= b_mag;
                        prem  <= '0;
                        neg_q <= a_neg ^ b_neg;
                        neg_r <= a_neg;
                        if (b == '0) begin
                            quot        <= '0;
                            rem         <= '0;
                            div_by_zero <= 1'b1;
                            state       <= S_DONE;
                        end else begin
                            div_by_zero <= 1'b0;
                            cnt         <= CW'(WIDTH);
                            state       <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    dvd  <= dvd_nxt;
                    prem <= prem_nxt;
                    cnt  <= cnt - CW'(1);
                    // Last iteration: this step's result feeds the outputs
                    // directly, so the counter lands on 0 as DONE is entered.
                    if (cnt == CW'(1)) begin
                        quot  <= q_fin;
                        rem   <= r_fin;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_v2f_divmod_seq.sv
module tb_v2f_divmod_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    // unsigned instance
    logic       iv_u = 1'b0, ir_u, ov_u, or_u = 1'b0, dz_u;
    logic [7:0] a_u = '0, b_u = '0, q_u, r_u;
    // signed instance
    logic       iv_s = 1'b0, ir_s, ov_s, or_s = 1'b0, dz_s;
    logic [7:0] a_s = '0, b_s = '0, q_s, r_s;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    v2f_divmod_seq #(.WIDTH(8), .SIGNED(0)) u_uns (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_u), .in_ready(ir_u),
        .a(a_u), .b(b_u), .out_valid(ov_u), .out_ready(or_u),
        .quot(q_u), .rem(r_u), .div_by_zero(dz_u)
    );

    v2f_divmod_seq #(.WIDTH(8), .SIGNED(1)) u_sgn (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_s), .in_ready(ir_s),
        .a(a_s), .b(b_s), .out_valid(ov_s), .out_ready(or_s),
        .quot(q_s), .rem(r_s), .div_by_zero(dz_s)
    );

    function automatic logic get_ov(input bit sel);
        return sel ? ov_s : ov_u;
    endfunction

    // Called at a falling edge; presents one request, waits for out_valid,
    // optionally drains. Returns at a falling edge.
    task automatic op(input bit sel, input logic [7:0] av, input logic [7:0] bv,
                      input bit drain, output logic [7:0] q, output logic [7:0] r,
                      output logic dz, output int lat, output int acc);
        acc = cyc;
        if (sel) begin a_s = av; b_s = bv; iv_s = 1'b1; end
        else     begin a_u = av; b_u = bv; iv_u = 1'b1; end
        @(negedge clk);
        iv_s = 1'b0;
        iv_u = 1'b0;
        a_s = 8'h5A; b_s = 8'h00;  // scramble: inputs after accept must be ignored
        a_u = 8'h5A; b_u = 8'h00;
        lat = 1;
        while (!get_ov(sel) && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        q  = sel ? q_s : q_u;
        r  = sel ? r_s : r_u;
        dz = sel ? dz_s : dz_u;
        if (drain) begin
            if (sel) or_s = 1'b1; else or_u = 1'b1;
            @(negedge clk);
            or_s = 1'b0;
            or_u = 1'b0;
        end
    endtask

    task automatic test_reset();
        n_cmp++; if (ir_u !== 1'b1 || ir_s !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready: got %b/%b want 1/1", ir_u, ir_s); end
        n_cmp++; if (ov_u !== 1'b0 || ov_s !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %b/%b want 0/0", ov_u, ov_s); end
        n_cmp++; if (q_u !== 8'h00 || r_u !== 8'h00 || dz_u !== 1'b0) begin n_bad++; $display("FAIL rst_uns_outs: got q=%h r=%h dz=%b want 0 0 0", q_u, r_u, dz_u); end
        n_cmp++; if (q_s !== 8'h00 || r_s !== 8'h00 || dz_s !== 1'b0) begin n_bad++; $display("FAIL rst_sgn_outs: got q=%h r=%h dz=%b want 0 0 0", q_s, r_s, dz_s); end
    endtask

    task automatic test_unsigned();
        logic [7:0] q, r; logic dz; int lat, acc;
        op(0, 8'd100, 8'd7, 1, q, r, dz, lat, acc);
        n_cmp++; if (lat !== 9) begin n_bad++; $display("FAIL uns_latency: got %0d want 9", lat); end
        n_cmp++; if (q !== 8'd14 || r !== 8'd2 || dz !== 1'b0) begin n_bad++; $display("FAIL uns_100_7: got q=%0d r=%0d dz=%b want 14 2 0", q, r, dz); end
        op(0, 8'd255, 8'd16, 1, q, r, dz, lat, acc);
        n_cmp++; if (q !== 8'd15 || r !== 8'd15) begin n_bad++; $display("FAIL uns_255_16: got q=%0d r=%0d want 15 15", q, r); end
        op(0, 8'd3, 8'd200, 1, q, r, dz, lat, acc);
        n_cmp++; if (q !== 8'd0 || r !== 8'd3) begin n_bad++; $display("FAIL uns_3_200: got q=%0d r=%0d want 0 3", q, r); end
        op(0, 8'd240, 8'd255, 1, q, r, dz, lat, acc);
        n_cmp++; if (q !== 8'd0 || r !== 8'd240) begin n_bad++; $display("FAIL uns_240_255: got q=%0d r=%0d want 0 240", q, r); end
    endtask

    task automatic test_signed();
        logic [7:0] q, r; logic dz; int lat, acc;
        op(1, 8'hF9, 8'h02, 1, q, r, dz, lat, acc);          // -7 / 2
        n_cmp++; if (lat !== 9) begin n_bad++; $display("FAIL sgn_latency: got %0d want 9", lat); end
        n_cmp++; if (q !== 8'hFD || r !== 8'hFF) begin n_bad++; $display("FAIL sgn_m7_2: got q=%h r=%h want fd ff", q, r); end
        op(1, 8'h07, 8'hFE, 1, q, r, dz, lat, acc);          // 7 / -2
        n_cmp++; if (q !== 8'hFD || r !== 8'h01) begin n_bad++; $display("FAIL sgn_7_m2: got q=%h r=%h want fd 01", q, r); end
        op(1, 8'hF9, 8'hFE, 1, q, r, dz, lat, acc);          // -7 / -2
        n_cmp++; if (q !== 8'h03 || r !== 8'hFF) begin n_bad++; $display("FAIL sgn_m7_m2: got q=%h r=%h want 03 ff", q, r); end
        op(1, 8'd127, 8'h80, 1, q, r, dz, lat, acc);         // 127 / -128
        n_cmp++; if (q !== 8'h00 || r !== 8'h7F) begin n_bad++; $display("FAIL sgn_127_m128: got q=%h r=%h want 00 7f", q, r); end
    endtask

    task automatic test_div_zero();
        logic [7:0] q, r; logic dz; int lat, acc, acc2;
        op(0, 8'd5, 8'd0, 1, q, r, dz, lat, acc);
        n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL dz_latency: got %0d want 1", lat); end
        n_cmp++; if (q !== 8'd0 || r !== 8'd0 || dz !== 1'b1) begin n_bad++; $display("FAIL dz_result: got q=%0d r=%0d dz=%b want 0 0 1", q, r, dz); end
        n_cmp++; if (dz_u !== 1'b1 || ir_u !== 1'b1) begin n_bad++; $display("FAIL dz_hold: got dz=%b rdy=%b want 1 1", dz_u, ir_u); end
        op(0, 8'd7, 8'd0, 1, q, r, dz, lat, acc);
        op(0, 8'd8, 8'd0, 1, q, r, dz, lat, acc2);
        n_cmp++; if (acc2 - acc !== 2) begin n_bad++; $display("FAIL dz_throughput: got %0d want 2", acc2 - acc); end
        op(0, 8'd9, 8'd3, 1, q, r, dz, lat, acc);
        n_cmp++; if (q !== 8'd3 || r !== 8'd0 || dz !== 1'b0) begin n_bad++; $display("FAIL dz_followup: got q=%0d r=%0d dz=%b want 3 0 0", q, r, dz); end
        op(1, 8'h80, 8'd0, 1, q, r, dz, lat, acc);
        n_cmp++; if (q !== 8'd0 || r !== 8'd0 || dz !== 1'b1) begin n_bad++; $display("FAIL dz_signed: got q=%h r=%h dz=%b want 00 00 1", q, r, dz); end
    endtask

    task automatic test_overflow();
        logic [7:0] q, r; logic dz; int lat, acc;
        op(1, 8'h80, 8'hFF, 1, q, r, dz, lat, acc);          // -128 / -1
        n_cmp++; if (q !== 8'h80 || r !== 8'h00 || dz !== 1'b0) begin n_bad++; $display("FAIL ovf_m128_m1: got q=%h r=%h dz=%b want 80 00 0", q, r, dz); end
        op(1, 8'h80, 8'h01, 1, q, r, dz, lat, acc);          // -128 / 1
        n_cmp++; if (q !== 8'h80 || r !== 8'h00) begin n_bad++; $display("FAIL ovf_m128_1: got q=%h r=%h want 80 00", q, r); end
        op(1, 8'h80, 8'h02, 1, q, r, dz, lat, acc);          // -128 / 2
        n_cmp++; if (q !== 8'hC0 || r !== 8'h00) begin n_bad++; $display("FAIL ovf_m128_2: got q=%h r=%h want c0 00", q, r); end
        op(1, 8'h80, 8'h07, 1, q, r, dz, lat, acc);          // -128 / 7 = -18 r -2
        n_cmp++; if (q !== 8'hEE || r !== 8'hFE) begin n_bad++; $display("FAIL ovf_m128_7: got q=%h r=%h want ee fe", q, r); end
    endtask

    task automatic test_backpressure();
        logic [7:0] q, r; logic dz; int lat, acc;
        op(0, 8'd50, 8'd6, 0, q, r, dz, lat, acc);
        n_cmp++; if (lat !== 9 || q !== 8'd8 || r !== 8'd2) begin n_bad++; $display("FAIL bp_first: got lat=%0d q=%0d r=%0d want 9 8 2", lat, q, r); end
        for (int i = 0; i < 5; i++) begin
            iv_u = 1'b1; a_u = 8'd99; b_u = 8'd9;
            @(negedge clk);
            n_cmp++; if (ov_u !== 1'b1 || ir_u !== 1'b0 || q_u !== 8'd8 || r_u !== 8'd2) begin
                n_bad++; $display("FAIL bp_hold%0d: got ov=%b rdy=%b q=%0d r=%0d want 1 0 8 2", i, ov_u, ir_u, q_u, r_u);
            end
        end
        iv_u = 1'b0;
        or_u = 1'b1;
        @(negedge clk);
        or_u = 1'b0;
        n_cmp++; if (ir_u !== 1'b1 || ov_u !== 1'b0 || q_u !== 8'd8 || r_u !== 8'd2) begin
            n_bad++; $display("FAIL bp_release: got rdy=%b ov=%b q=%0d r=%0d want 1 0 8 2", ir_u, ov_u, q_u, r_u);
        end
        @(negedge clk);
        n_cmp++; if (ir_u !== 1'b1 || ov_u !== 1'b0) begin n_bad++; $display("FAIL bp_no_queue: got rdy=%b ov=%b want 1 0", ir_u, ov_u); end
        // out_ready held high while idle must not disturb anything
        or_u = 1'b1;
        @(negedge clk);
        or_u = 1'b0;
        n_cmp++; if (ir_u !== 1'b1 || q_u !== 8'd8) begin n_bad++; $display("FAIL bp_idle_ready: got rdy=%b q=%0d want 1 8", ir_u, q_u); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] q, r; logic dz; int lat, acc, acc2;
        op(1, 8'd100, 8'hF9, 1, q, r, dz, lat, acc);         // 100 / -7
        n_cmp++; if (q !== 8'hF2 || r !== 8'h02) begin n_bad++; $display("FAIL b2b_first: got q=%h r=%h want f2 02", q, r); end
        op(1, 8'h9C, 8'd7, 1, q, r, dz, lat, acc2);          // -100 / 7
        n_cmp++; if (q !== 8'hF2 || r !== 8'hFE) begin n_bad++; $display("FAIL b2b_second: got q=%h r=%h want f2 fe", q, r); end
        n_cmp++; if (acc2 - acc !== 10) begin n_bad++; $display("FAIL b2b_throughput: got %0d want 10", acc2 - acc); end
    endtask

    task automatic test_reset_abort();
        logic [7:0] q, r; logic dz; int lat, acc, seen;
        iv_u = 1'b1; a_u = 8'd77; b_u = 8'd5;
        @(negedge clk);                                      // cycle 1
        iv_u = 1'b0;
        @(negedge clk);                                      // cycle 2
        @(negedge clk);                                      // cycle 3
        n_cmp++; if (ir_u !== 1'b0) begin n_bad++; $display("FAIL abort_in_calc: got rdy=%b want 0", ir_u); end
        rst_n = 1'b0;
        #2;
        n_cmp++; if (ir_u !== 1'b1 || ov_u !== 1'b0 || q_u !== 8'd0 || r_u !== 8'd0 || dz_u !== 1'b0) begin
            n_bad++; $display("FAIL abort_async: got rdy=%b ov=%b q=%0d r=%0d dz=%b want 1 0 0 0 0", ir_u, ov_u, q_u, r_u, dz_u);
        end
        n_cmp++; if (q_s !== 8'd0 || r_s !== 8'd0) begin n_bad++; $display("FAIL abort_sgn: got q=%h r=%h want 00 00", q_s, r_s); end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (ov_u === 1'b1) seen++;
        end
        n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL abort_spurious: got %0d valid cycles want 0", seen); end
        op(0, 8'd200, 8'd10, 1, q, r, dz, lat, acc);
        n_cmp++; if (lat !== 9 || q !== 8'd20 || r !== 8'd0 || dz !== 1'b0) begin
            n_bad++; $display("FAIL abort_resume: got lat=%0d q=%0d r=%0d dz=%b want 9 20 0 0", lat, q, r, dz);
        end
    endtask

    initial begin
        #12;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_unsigned();
        test_signed();
        test_div_zero();
        test_overflow();
        test_backpressure();
        test_back_to_back();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/v2f_divmod_seq.md
# v2f_divmod_seq

Multi-cycle, parametrised integer divide/modulo unit producing quotient and remainder together from one request. It is the sequential successor to the single-operation `v2f_div` / `v2f_mod` blackboxes. It is used where a combinational divider is too costly or where divide results must be pipelined behind a valid/ready handshake. Division semantics match the Factorio arithmetic combinator: truncation toward zero, and x/0 = x%0 = 0.

## Interface

Parameters:
- `WIDTH`, 32: operand and result width in bits (≥ 2).
- `SIGNED`, 1: 1 selects two's-complement operands and results; 0 selects unsigned.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `in_valid`, input, 1: request valid.
- `in_ready`, output, 1: unit can accept a request.
- `a`, input, WIDTH: dividend.
- `b`, input, WIDTH: divisor.
- `out_valid`, output, 1: result valid.
- `out_ready`, input, 1: consumer accepts the result.
- `quot`, output, WIDTH: quotient.
- `rem`, output, WIDTH: remainder.
- `div_by_zero`, output, 1: the result came from `b == 0`.

## Operation

- **FSM states:** IDLE, CALC, DONE.
- **IDLE:**
  - `in_ready` = 1, `out_valid` = 0.
  - On `in_valid && in_ready`, latch the magnitudes of `a` and `b`, the sign of `a`, and the sign of `a` XOR the sign of `b`.
  - If `b == 0`: load `quot` = 0, `rem` = 0, `div_by_zero` = 1, then go to DONE.
  - Otherwise clear `div_by_zero`, load the iteration counter with WIDTH, then go to CALC.
- **CALC:**
  - Restoring shift-subtract, one quotient bit per cycle, MSB first.
  - Use a WIDTH+1-bit partial remainder to avoid overflow.
  - When the counter reaches 0, apply sign correction, register `quot` and `rem`, then go to DONE.
  - `in_ready` = 0.
- **Sign correction** (SIGNED=1 only):
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
  - Magnitude of the most negative value is computed in WIDTH+1 bits.
  - MIN / −1 wraps: `quot` = MIN, `rem` = 0. No flag is raised.
- **DONE:**
  - `out_valid` = 1; `quot`, `rem`, `div_by_zero` are stable.
  - On `out_ready`, go to IDLE.
  - `in_ready` = 0 throughout DONE, so accept and drain never overlap.
- **Output hold:** `quot`, `rem`, `div_by_zero` keep their last values after the result is consumed, until the next result loads.
- **Input sampling:** `a` and `b` are sampled only on the accept edge; changes afterwards are ignored.

## Timing

- **Reset values:** state = IDLE, `in_ready` = 1, `out_valid` = 0, `quot` = 0, `rem` = 0, `div_by_zero` = 0, counter = 0.
- **Accept cycle:** the request is accepted in cycle 0 (the edge ending cycle 0).
- **Normal latency:** CALC occupies cycles 1..WIDTH; `out_valid` rises in cycle WIDTH+1.
- **Divide-by-zero latency:** `out_valid` rises in cycle 1.
- **Throughput:**
  - Normal: one result per WIDTH+2 cycles with `out_ready` held high. After the drain edge, IDLE is reached and the next accept is possible in that cycle.
  - Divide-by-zero: 2 cycles per result.
- **Backpressure:** `out_valid` and the results hold indefinitely while `out_ready` = 0.
- **`out_ready` outside DONE:** ignored.
- **`in_valid` outside IDLE:** ignored; the request is not queued, and the producer must hold it.
- **Reset mid-operation:** asserting `rst_n` low in CALC or DONE aborts immediately. The result is discarded and all outputs take their reset values asynchronously. No spurious `out_valid` occurs after release.
- **Combinational outputs:** `in_ready` depends on state only. `out_valid` has no combinational path from `in_valid`.

## Test plan

- **Unsigned:** WIDTH=8, SIGNED=0, a=100, b=7 accepted in cycle 0 → `out_valid` in cycle 9 with `quot`=14, `rem`=2, `div_by_zero`=0.
- **Signed:** WIDTH=8, SIGNED=1, the pair (a, b) in order (−7, 2), (7, −2), (−7, −2) → quot/rem of (−3, −1), (−3, 1), (3, −1) respectively.
- **Divide by zero:** a=5, b=0 → `out_valid` in cycle 1 with `quot`=0, `rem`=0, `div_by_zero`=1. A following request 9/3 → 3, 0 with `div_by_zero`=0.
- **Overflow:** WIDTH=8, SIGNED=1, a=−128, b=−1 → `quot`=−128 (0x80), `rem`=0. Also a=−128, b=1 → `quot`=−128.
- **Backpressure:** hold `out_ready`=0 for 5 cycles after `out_valid` rises. Results stay constant, `in_ready` stays 0, and `in_valid` pulses are ignored. Raising `out_ready` gives `in_ready`=1 in the next cycle.
- **Reset abort:** pulse `rst_n` low in CALC cycle 3 → all outputs return to reset values asynchronously, with no `out_valid` afterwards. A new request 200/10 (unsigned) returns 20, 0 with normal latency.
